hue_sequencer: RTL and testbench

HUE_SEQUENCER -- requirements
Module: hue_sequencer

---
 rtl/fade_pkg.sv | 42 ++++
 rtl/step_prescaler.sv | 37 +++
 rtl/hue_sequencer.sv | 115 +++++++++++
 tb/tb_hue_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fade_pkg.sv
// rtl/fade_pkg.sv - hue phase encoding and per-phase ramp lookup
package fade_pkg;

  typedef enum logic [2:0] {
    PH_RY = 3'd0,
    PH_YG = 3'd1,
    PH_GC = 3'd2,
    PH_CB = 3'd3,
    PH_BM = 3'd4,
    PH_MR = 3'd5
  } phase_t;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_t;

  typedef struct packed {
    chan_t ch;
    logic  up;
  } ramp_t;

  // Which channel moves in each phase, and in which direction.
  function automatic ramp_t ramp_of(input phase_t ph);
    ramp_t r;
    case (ph)
      PH_RY:   r = '{ch: CH_G, up: 1'b1};
      PH_YG:   r = '{ch: CH_R, up: 1'b0};
      PH_GC:   r = '{ch: CH_B, up: 1'b1};
      PH_CB:   r = '{ch: CH_G, up: 1'b0};
      PH_BM:   r = '{ch: CH_R, up: 1'b1};
      default: r = '{ch: CH_B, up: 1'b0};
    endcase
    return r;
  endfunction

  function automatic phase_t next_phase(input phase_t ph);
    return (ph == PH_MR) ? PH_RY : phase_t'(ph + 3'd1);
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// rtl/step_prescaler.sv - free-running step prescaler with hold and clear
module step_prescaler #(
  parameter int INTERVAL = 24000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(INTERVAL);
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational so the step lands on the same edge as the wrap.
  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/hue_sequencer.sv
// rtl/hue_sequencer.sv - six-phase RGB hue wheel duty sequencer
module hue_sequencer
  import fade_pkg::*;
#(
  parameter  int STEP_INTERVAL   = 24000,
  parameter  int STEPS_PER_PHASE = 200,
  parameter  int PWM_INTERVAL    = 1200,
  localparam int STEP_VAL        = (STEPS_PER_PHASE > 0) ? PWM_INTERVAL / STEPS_PER_PHASE : 0,
  localparam int DW              = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          restart,
  output logic [DW-1:0] pwm_r,
  output logic [DW-1:0] pwm_g,
  output logic [DW-1:0] pwm_b,
  output logic [2:0]    phase,
  output logic          step_tick,
  output logic          wheel_done
);

  localparam int            SW        = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS_PER_PHASE - 1);
  localparam logic [DW-1:0] FULL      = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] INC       = DW'(STEP_VAL);

  if (STEP_INTERVAL < 2 || STEPS_PER_PHASE < 1 || STEP_VAL < 1) begin : g_param_check
    $error("hue_sequencer: STEP_INTERVAL>=2, STEPS_PER_PHASE>=1 and STEP_VAL>=1 required");
  end

  logic [DW-1:0] pwm_r_q, pwm_r_d, pwm_g_q, pwm_g_d, pwm_b_q, pwm_b_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  phase_t        phase_q, phase_d;
  logic          step_tick_q, step_tick_d, wheel_done_q, wheel_done_d;
  logic          tick, step, final_step;
  ramp_t         rr;

  step_prescaler #(
    .INTERVAL(STEP_INTERVAL)
  ) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .clear (restart),
    .tick  (tick)
  );

  assign step       = tick && !restart;
  assign final_step = (step_cnt_q == LAST_STEP);
  assign rr         = ramp_of(phase_q);

  // The last step of a phase snaps to the rail so truncation never accumulates.
  function automatic logic [DW-1:0] ramp(input logic [DW-1:0] cur, input logic up,
                                         input logic last);
    if (up) return (last || cur >= FULL - INC) ? FULL : cur + INC;
    else    return (last || cur <= INC) ? '0 : cur - INC;
  endfunction

  always_comb begin
    pwm_r_d      = pwm_r_q;
    pwm_g_d      = pwm_g_q;
    pwm_b_d      = pwm_b_q;
    step_cnt_d   = step_cnt_q;
    phase_d      = phase_q;
    step_tick_d  = step;
    wheel_done_d = step && final_step && (phase_q == PH_MR);
    if (step) begin
      step_cnt_d = final_step ? '0 : step_cnt_q + 1'b1;
      if (final_step) phase_d = next_phase(phase_q);
      case (rr.ch)
        CH_R:    pwm_r_d = ramp(pwm_r_q, rr.up, final_step);
        CH_G:    pwm_g_d = ramp(pwm_g_q, rr.up, final_step);
        default: pwm_b_d = ramp(pwm_b_q, rr.up, final_step);
      endcase
    end
    if (restart) begin
      pwm_r_d      = FULL;
      pwm_g_d      = '0;
      pwm_b_d      = '0;
      step_cnt_d   = '0;
      phase_d      = PH_RY;
      step_tick_d  = 1'b0;
      wheel_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r_q      <= FULL;
      pwm_g_q      <= '0;
      pwm_b_q      <= '0;
      step_cnt_q   <= '0;
      phase_q      <= PH_RY;
      step_tick_q  <= 1'b0;
      wheel_done_q <= 1'b0;
    end else begin
      pwm_r_q      <= pwm_r_d;
      pwm_g_q      <= pwm_g_d;
      pwm_b_q      <= pwm_b_d;
      step_cnt_q   <= step_cnt_d;
      phase_q      <= phase_d;
      step_tick_q  <= step_tick_d;
      wheel_done_q <= wheel_done_d;
    end
  end

  assign pwm_r      = pwm_r_q;
  assign pwm_g      = pwm_g_q;
  assign pwm_b      = pwm_b_q;
  assign phase      = phase_q;
  assign step_tick  = step_tick_q;
  assign wheel_done = wheel_done_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// tb/tb_hue_sequencer.sv - self-checking bench for hue_sequencer (4/4/100 and 4/3/10)
module tb_hue_sequencer;

  localparam int SI = 4;

  logic       clk = 1'b0;
  logic       rst_n, enable, restart;
  logic [6:0] a_r, a_g, a_b;
  logic [3:0] b_r, b_g, b_b;
  logic [2:0] a_ph, b_ph;
  logic       a_tick, a_done, b_tick, b_done;

  int checks = 0;
  int errors = 0;
  int p, k, tick_m, done_a, done_b;
  int n_tick, n_done_a, n_done_b;

  always #5 clk = ~clk;

  hue_sequencer #(.STEP_INTERVAL(4), .STEPS_PER_PHASE(4), .PWM_INTERVAL(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .pwm_r(a_r), .pwm_g(a_g), .pwm_b(a_b), .phase(a_ph),
    .step_tick(a_tick), .wheel_done(a_done)
  );

  hue_sequencer #(.STEP_INTERVAL(4), .STEPS_PER_PHASE(3), .PWM_INTERVAL(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .pwm_r(b_r), .pwm_g(b_g), .pwm_b(b_b), .phase(b_ph),
    .step_tick(b_tick), .wheel_done(b_done)
  );

  // Colour after k steps, from the phase table: which rails are full and how far the ramp has moved.
  function automatic int exp_chan(input int kk, input int spp, input int full, input int c);
    int ph = (kk / spp) % 6;
    int s  = kk % spp;
    int sv = full / spp;
    int up = (s * sv > full) ? full : s * sv;
    int dn = (full - s * sv < 0) ? 0 : full - s * sv;
    int rgb[3];
    case (ph)
      0:       rgb = '{full, up, 0};
      1:       rgb = '{dn, full, 0};
      2:       rgb = '{0, full, up};
      3:       rgb = '{0, dn, full};
      4:       rgb = '{up, 0, full};
      default: rgb = '{full, 0, dn};
    endcase
    return rgb[c];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    p = 0; k = 0; tick_m = 0; done_a = 0; done_b = 0;
  endtask

  task automatic model_edge();
    if (!rst_n || restart) begin
      model_reset();
    end else if (enable && p == SI - 1) begin
      p = 0; k++; tick_m = 1;
      done_a = (k % 24 == 0) ? 1 : 0;
      done_b = (k % 18 == 0) ? 1 : 0;
    end else begin
      if (enable) p++;
      tick_m = 0; done_a = 0; done_b = 0;
    end
  endtask

  task automatic check_all();
    chk("a_pwm_r", a_r, exp_chan(k, 4, 100, 0));
    chk("a_pwm_g", a_g, exp_chan(k, 4, 100, 1));
    chk("a_pwm_b", a_b, exp_chan(k, 4, 100, 2));
    chk("a_phase", a_ph, (k / 4) % 6);
    chk("a_step_tick", a_tick, tick_m);
    chk("a_wheel_done", a_done, done_a);
    chk("b_pwm_r", b_r, exp_chan(k, 3, 10, 0));
    chk("b_pwm_g", b_g, exp_chan(k, 3, 10, 1));
    chk("b_pwm_b", b_b, exp_chan(k, 3, 10, 2));
    chk("b_phase", b_ph, (k / 3) % 6);
    chk("b_step_tick", b_tick, tick_m);
    chk("b_wheel_done", b_done, done_b);
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      enable  = ($urandom_range(0, 9) < 8);
      restart = ($urandom_range(0, 49) == 0);
      step_cycle();
    end
    enable = 1'b1; restart = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; restart = 1'b0;
    model_reset();
    step_cycle();
    step_cycle();

    rst_n = 1'b1; enable = 1'b1;
    n_tick = 0; n_done_a = 0; n_done_b = 0;
    for (int i = 0; i < 96; i++) begin
      step_cycle();
      if (i < 16 && a_tick) n_tick++;
      if (a_done) n_done_a++;
      if (b_done) n_done_b++;
      if (i == 3)  chk("a_g_first", a_g, 25);
      if (i == 15) begin chk("a_g_forced", a_g, 100); chk("a_ph_1", a_ph, 1); end
      if (i == 3)  chk("b_g_first", b_g, 3);
      if (i == 11) chk("b_g_forced", b_g, 10);
      if (i == 19) chk("b_r_second", b_r, 4);
      if (i == 23) chk("b_r_forced", b_r, 0);
    end
    chk("a_ticks_16", n_tick, 4);
    chk("a_wheel_once", n_done_a, 1);
    chk("b_wheel_once", n_done_b, 1);
    chk("wheel_end_r", a_r, 100);
    chk("wheel_end_g", a_g, 0);
    chk("wheel_end_ph", a_ph, 0);

    step_cycle();
    step_cycle();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step_cycle();
    enable = 1'b1;
    n_tick = 0;
    for (int i = 0; i < 12; i++) begin
      step_cycle();
      if (a_tick) n_tick++;
    end
    chk("resume_ticks", n_tick, 3);

    for (int i = 0; i < 200; i++) begin
      if ((k / 4) % 6 == 3 && p == SI - 1) break;
      step_cycle();
    end
    restart = 1'b1;
    step_cycle();
    restart = 1'b0;
    chk("restart_r", a_r, 100);
    chk("restart_tick", a_tick, 0);

    random_run(400);

    for (int i = 0; i < 200; i++) begin
      if ((k / 4) % 6 == 4 && p == 1) break;
      step_cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_r", a_r, 100);
    chk("async_ph", a_ph, 0);
    check_all();
    step_cycle();
    rst_n = 1'b1;

    random_run(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
